usb_fs_in_rr_arb: RTL

USB_FS_IN_RR_ARB -- requirements
Module: usb_fs_in_rr_arb

---
 rtl/usb_fs_pkg.sv | 28 ++
 rtl/usb_fs_rr_pick.sv | 39 +++
 rtl/usb_fs_in_rr_arb.sv | 113 +++++++++++
 3 files changed

// File: rtl/usb_fs_pkg.sv
// Shared constants for the USB full-speed engine.
//   arb_state_t : IN-arbiter state encoding (IDLE=0, LOCKED=1)
//   PID_*       : 4-bit packet identifiers
//   idx_width() : width of an index into n requesters (never below 1)
package usb_fs_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam int MAX_EPS = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usb_fs_rr_pick.sv
// Rotating first-one search: starting at ptr and searching upward with
// wrap-around, returns the first asserted req bit as a one-hot pick and
// its index. Purely combinational.
//   req  : request vector
//   ptr  : search start position (0..WIDTH-1)
//   pick : one-hot (or zero) winner
//   idx  : index of the winner (0 when no request)
module usb_fs_rr_pick
    import usb_fs_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [WIDTH-1:0] pick,
    output logic [IDX_W-1:0] idx
);

    logic        found;
    int unsigned pos;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pos = i + 32'(ptr);
            if (pos >= 32'(WIDTH)) pos = pos - 32'(WIDTH);
            if (!found && req[pos]) begin
                found     = 1'b1;
                pick[pos] = 1'b1;
                idx       = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/usb_fs_in_rr_arb.sv
// Round-robin arbiter for the IN data path. While idle it re-arbitrates
// every cycle; an in_xfr_start with a live grant freezes that grant until
// in_xfr_end (or the lock watchdog), after which priority moves past the
// served endpoint.
//   clk, reset     : clock, asynchronous active-high reset
//   in_ep_req      : per-endpoint request
//   in_ep_data     : per-endpoint byte, endpoint i at [i*8 +: 8]
//   in_ep_grant    : registered one-hot-or-zero grant
//   in_xfr_start   : transaction start pulse
//   in_xfr_end     : transaction end pulse
//   arb_in_ep_data : byte of the granted endpoint, 0 when none
//   arb_locked     : grant frozen for a transaction
//   arb_timeout    : one-cycle pulse when the lock watchdog expires
module usb_fs_in_rr_arb
    import usb_fs_pkg::*;
#(
    parameter int NUM_IN_EPS   = 1,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN_EPS-1:0]   in_ep_req,
    input  logic [NUM_IN_EPS*8-1:0] in_ep_data,
    output logic [NUM_IN_EPS-1:0]   in_ep_grant,
    input  logic                    in_xfr_start,
    input  logic                    in_xfr_end,
    output logic [7:0]              arb_in_ep_data,
    output logic                    arb_locked,
    output logic                    arb_timeout
);

    localparam int IDX_W = idx_width(NUM_IN_EPS);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IN_EPS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    arb_state_t            state, state_nxt;
    logic [IDX_W-1:0]      ptr, ptr_nxt;
    logic [IDX_W-1:0]      grant_idx, grant_idx_nxt;
    logic [NUM_IN_EPS-1:0] grant_nxt;
    logic [CNT_W-1:0]      lock_cnt, lock_cnt_nxt;
    logic [NUM_IN_EPS-1:0] pick;
    logic [IDX_W-1:0]      pick_idx;

    usb_fs_rr_pick #(
        .WIDTH (NUM_IN_EPS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (in_ep_req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx)
    );

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        grant_nxt     = in_ep_grant;
        grant_idx_nxt = grant_idx;
        lock_cnt_nxt  = lock_cnt;
        arb_timeout   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (in_xfr_start && (in_ep_grant != '0)) begin
                    state_nxt    = ARB_LOCKED;
                    lock_cnt_nxt = '0;
                end else begin
                    grant_nxt     = pick;
                    grant_idx_nxt = pick_idx;
                end
            end
            ARB_LOCKED: begin
                arb_timeout = (lock_cnt == CNT_LAST);
                // Watchdog expiry is handled exactly like a normal end.
                if (in_xfr_end || arb_timeout) begin
                    state_nxt    = ARB_IDLE;
                    grant_nxt    = '0;
                    lock_cnt_nxt = '0;
                    ptr_nxt      = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
                end else if (lock_cnt != '1) begin
                    lock_cnt_nxt = lock_cnt + 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            ptr         <= '0;
            in_ep_grant <= '0;
            grant_idx   <= '0;
            lock_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            in_ep_grant <= grant_nxt;
            grant_idx   <= grant_idx_nxt;
            lock_cnt    <= lock_cnt_nxt;
        end
    end

    always_comb begin
        arb_in_ep_data = '0;
        for (int unsigned i = 0; i < NUM_IN_EPS; i++) begin
            if (in_ep_grant[i]) arb_in_ep_data = arb_in_ep_data | in_ep_data[i*8 +: 8];
        end
    end

    assign arb_locked = (state == ARB_LOCKED);

endmodule
